// File: rtl/framebuffer_pkg.sv
// Shared types and helpers for the 128x64 monochrome page-layout frame buffer.
// Byte = 8 vertical pixels of one page, LSB is the top row of that page.
package framebuffer_pkg;

    localparam int FB_BYTES = 1024;
    localparam int FB_AW    = 10;

    typedef enum logic [1:0] {
        OP_CLR = 2'b00,
        OP_SET = 2'b01,
        OP_TGL = 2'b10,
        OP_NOP = 2'b11
    } px_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_FILL = 2'b11
    } fb_state_e;

    function automatic logic [FB_AW-1:0] fb_byte_addr(
        input logic [6:0] x,
        input logic [5:0] y
    );
        return {y[5:3], x};
    endfunction

endpackage

// File: rtl/fb_ram_dp.sv
// Simple dual-port byte RAM: port A read-only (display), port B read+write.
// Both ports are read-first on an address collision with a port B write.
module fb_ram_dp #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [AW-1:0] a_addr,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    input  logic          b_we,
    input  logic [7:0]    b_wdata,
    output logic [7:0]    b_rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        b_rdata <= mem[b_addr];
    end

    // Only the display output register is reset; array contents are kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_rdata <= '0;
        end else begin
            a_rdata <= mem[a_addr];
        end
    end

endmodule

// File: rtl/pixel_framebuffer.sv
// Frame buffer feeding the SSD1306 driver: display read port, single-pixel
// read-modify-write draw commands and a whole-frame fill.
module pixel_framebuffer
    import framebuffer_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int HEIGHT         = 64,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] pixel_address_i,
    output logic [7:0] pixel_data_o,
    input  logic       px_valid_i,
    output logic       px_ready_o,
    input  logic [6:0] px_x_i,
    input  logic [5:0] px_y_i,
    input  logic [1:0] px_op_i,
    input  logic       clear_req_i,
    input  logic       clear_fill_i,
    output logic       busy_o
);

    localparam logic [7:0] X_LIM = 8'(WIDTH);
    localparam logic [7:0] Y_LIM = 8'(HEIGHT);
    localparam logic [FB_AW-1:0] CNT_LAST = FB_AW'(FB_BYTES - 1);

    fb_state_e state_q, state_d;

    logic [FB_AW-1:0] cmd_addr_q;
    logic [2:0]       cmd_bit_q;
    px_op_e           cmd_op_q;
    logic             cmd_hit_q;

    logic [FB_AW-1:0] cnt_q;
    logic [7:0]       fill_q;
    logic             pend_q;
    logic [7:0]       pend_fill_q;

    logic [7:0]       req_fill;
    logic             accept;
    logic             in_range;
    logic             fill_start;
    logic [7:0]       fill_start_val;

    logic [FB_AW-1:0] b_addr;
    logic             b_we;
    logic [7:0]       b_wdata;
    logic [7:0]       b_rdata;
    logic [7:0]       bit_mask;
    logic [7:0]       mod_byte;

    assign req_fill = {8{clear_fill_i}};
    assign accept   = px_valid_i & px_ready_o & ~clear_req_i;
    assign in_range = ({1'b0, px_x_i} < X_LIM) && ({2'b00, px_y_i} < Y_LIM);

    always_comb begin
        state_d        = state_q;
        fill_start     = 1'b0;
        fill_start_val = req_fill;
        unique case (state_q)
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d    = ST_FILL;
                    fill_start = 1'b1;
                end else if (accept) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WR;
            end
            ST_WR: begin
                if (clear_req_i || pend_q) begin
                    state_d        = ST_FILL;
                    fill_start     = 1'b1;
                    fill_start_val = clear_req_i ? req_fill : pend_fill_q;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (clear_req_i) begin
                    fill_start = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        bit_mask = 8'b1 << cmd_bit_q;
        mod_byte = b_rdata;
        unique case (cmd_op_q)
            OP_CLR:  mod_byte = b_rdata & ~bit_mask;
            OP_SET:  mod_byte = b_rdata | bit_mask;
            OP_TGL:  mod_byte = b_rdata ^ bit_mask;
            OP_NOP:  mod_byte = b_rdata;
            default: mod_byte = b_rdata;
        endcase
    end

    // Write enable is gated by reset so an aborted command never lands.
    always_comb begin
        b_addr  = cmd_addr_q;
        b_wdata = mod_byte;
        b_we    = 1'b0;
        if (state_q == ST_FILL) begin
            b_addr  = cnt_q;
            b_wdata = fill_q;
            b_we    = ~rst_i;
        end else if (state_q == ST_WR) begin
            b_we = ~rst_i & cmd_hit_q & (cmd_op_q != OP_NOP);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= CLEAR_ON_RESET ? ST_FILL : ST_IDLE;
            cmd_addr_q  <= '0;
            cmd_bit_q   <= '0;
            cmd_op_q    <= OP_NOP;
            cmd_hit_q   <= 1'b0;
            cnt_q       <= '0;
            fill_q      <= '0;
            pend_q      <= 1'b0;
            pend_fill_q <= '0;
            px_ready_o  <= 1'b0;
            busy_o      <= CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            px_ready_o <= (state_d == ST_IDLE);
            busy_o     <= (state_d != ST_IDLE);
            if (state_q == ST_IDLE && accept) begin
                cmd_addr_q <= fb_byte_addr(px_x_i, px_y_i);
                cmd_bit_q  <= px_y_i[2:0];
                cmd_op_q   <= px_op_e'(px_op_i);
                cmd_hit_q  <= in_range;
            end
            if (fill_start) begin
                cnt_q  <= '0;
                fill_q <= fill_start_val;
                pend_q <= 1'b0;
            end else if (state_q == ST_FILL && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == ST_RD && clear_req_i) begin
                pend_q      <= 1'b1;
                pend_fill_q <= req_fill;
            end
        end
    end

    fb_ram_dp #(
        .DEPTH (FB_BYTES),
        .AW    (FB_AW)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_addr  (pixel_address_i),
        .a_rdata (pixel_data_o),
        .b_addr  (b_addr),
        .b_we    (b_we),
        .b_wdata (b_wdata),
        .b_rdata (b_rdata)
    );

endmodule

// File: tb/tb_pixel_framebuffer.sv
// Directed bench for pixel_framebuffer: reset fill, draws, fills, collisions
// and reset in the middle of a fill.
module tb_pixel_framebuffer;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [9:0] pixel_address_i = '0;
    logic [7:0] pixel_data_o;
    logic       px_valid_i = 1'b0;
    logic       px_ready_o;
    logic [6:0] px_x_i = '0;
    logic [5:0] px_y_i = '0;
    logic [1:0] px_op_i = '0;
    logic       clear_req_i = 1'b0;
    logic       clear_fill_i = 1'b0;
    logic       busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] model [1024];

    pixel_framebuffer #(
        .WIDTH          (128),
        .HEIGHT         (64),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pixel_address_i (pixel_address_i),
        .pixel_data_o    (pixel_data_o),
        .px_valid_i      (px_valid_i),
        .px_ready_o      (px_ready_o),
        .px_x_i          (px_x_i),
        .px_y_i          (px_y_i),
        .px_op_i         (px_op_i),
        .clear_req_i     (clear_req_i),
        .clear_fill_i    (clear_fill_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, need finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h need %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic read_byte(input logic [9:0] a, output logic [7:0] d);
        pixel_address_i = a;
        step();
        d = pixel_data_o;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy_o && n < 5000) begin
            n++;
            step();
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!px_ready_o && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) chk({tag, "_rdy_to"}, 32'(n), 32'd0);
    endtask

    task automatic scan(input string tag);
        int bad = 0;
        logic [7:0] d;
        for (int a = 0; a < 1024; a++) begin
            read_byte(10'(a), d);
            if (d !== model[a]) bad++;
        end
        chk(tag, 32'(bad), 32'd0);
    endtask

    task automatic fill_model(input logic [7:0] v);
        for (int a = 0; a < 1024; a++) model[a] = v;
    endtask

    // Returns display data at the WR edge (old) and one edge later (new).
    task automatic draw(input logic [6:0] x, input logic [5:0] y,
                        input logic [1:0] op, input logic [9:0] addr,
                        input string tag,
                        output logic [7:0] old_d, output logic [7:0] new_d);
        pixel_address_i = addr;
        wait_ready(tag);
        px_x_i = x;
        px_y_i = y;
        px_op_i = op;
        px_valid_i = 1'b1;
        step();
        px_valid_i = 1'b0;
        chk({tag, "_rdy_drop"}, 32'(px_ready_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        step();
        step();
        old_d = pixel_data_o;
        step();
        new_d = pixel_data_o;
    endtask

    initial begin
        int n;
        logic [7:0] o, w, d;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_data", 32'(pixel_data_o), 32'd0);
        chk("rst_ready", 32'(px_ready_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b0;
        busy_len(n);
        chk("init_busy_len", 32'(n), 32'd1024);
        chk("init_ready", 32'(px_ready_o), 32'd1);
        fill_model(8'h00);
        scan("init_zero");

        draw(7'd5, 6'd10, 2'b01, 10'd133, "set5_10", o, w);
        chk("set5_10_old", 32'(o), 32'h00);
        chk("set5_10_new", 32'(w), 32'h04);
        draw(7'd5, 6'd10, 2'b10, 10'd133, "tgl5_10", o, w);
        chk("tgl5_10_old", 32'(o), 32'h04);
        chk("tgl5_10_new", 32'(w), 32'h00);

        draw(7'd0, 6'd0, 2'b01, 10'd0, "set0_0", o, w);
        chk("set0_0_new", 32'(w), 32'h01);
        draw(7'd0, 6'd7, 2'b01, 10'd0, "set0_7", o, w);
        chk("set0_7_new", 32'(w), 32'h81);
        draw(7'd127, 6'd63, 2'b01, 10'd1023, "set127_63", o, w);
        chk("set127_63_old", 32'(o), 32'h00);
        chk("set127_63_new", 32'(w), 32'h80);
        model[0] = 8'h81;
        model[1023] = 8'h80;
        scan("corners");
        draw(7'd0, 6'd0, 2'b11, 10'd0, "nop0_0", o, w);
        chk("nop0_0_new", 32'(w), 32'h81);
        draw(7'd0, 6'd7, 2'b00, 10'd0, "clr0_7", o, w);
        chk("clr0_7_new", 32'(w), 32'h01);

        // Fill request arrives while a set is in RD.
        pixel_address_i = 10'd3;
        wait_ready("pend");
        px_x_i = 7'd3;
        px_y_i = 6'd0;
        px_op_i = 2'b01;
        px_valid_i = 1'b1;
        step();
        px_valid_i = 1'b0;
        clear_req_i = 1'b1;
        clear_fill_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        clear_fill_i = 1'b0;
        step();
        step();
        chk("pend_draw_done", 32'(pixel_data_o), 32'h01);
        busy_len(n);
        chk("pend_busy_end", 32'(busy_o), 32'd0);
        fill_model(8'hFF);
        scan("pend_all_ff");

        // Fill and draw offered in the same IDLE cycle; fill wins.
        wait_ready("prio");
        px_x_i = 7'd1;
        px_y_i = 6'd1;
        px_op_i = 2'b01;
        px_valid_i = 1'b1;
        clear_req_i = 1'b1;
        clear_fill_i = 1'b0;
        step();
        clear_req_i = 1'b0;
        chk("prio_ready", 32'(px_ready_o), 32'd0);
        busy_len(n);
        chk("prio_busy_len", 32'(n), 32'd1024);
        step();
        px_valid_i = 1'b0;
        chk("prio_accept", 32'(busy_o), 32'd1);
        busy_len(n);
        fill_model(8'h00);
        model[1] = 8'h02;
        scan("prio_frame");

        // Reset during a 0xFF fill after 300 bytes.
        wait_ready("rstfill");
        clear_req_i = 1'b1;
        clear_fill_i = 1'b1;
        step();
        clear_req_i = 1'b0;
        clear_fill_i = 1'b0;
        repeat (300) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rstfill_data", 32'(pixel_data_o), 32'd0);
        chk("rstfill_ready", 32'(px_ready_o), 32'd0);
        chk("rstfill_busy", 32'(busy_o), 32'd1);
        repeat (3) step();
        rst_i = 1'b0;
        repeat (100) step();
        read_byte(10'd50, d);
        chk("refill_50", 32'(d), 32'h00);
        read_byte(10'd200, d);
        chk("refill_200", 32'(d), 32'hFF);
        read_byte(10'd600, d);
        chk("aborted_600", 32'(d), 32'h00);
        busy_len(n);
        chk("refill_done", 32'(busy_o), 32'd0);
        fill_model(8'h00);
        scan("refill_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
